// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, control FSM states and write-back select encoding shared by the MIPS core.
package mips_pkg;
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_ADDU   = 6'h21;
  localparam logic [5:0] FUNCT_JR     = 6'h08;
  typedef enum logic [2:0] {ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_HALT} ctrl_state_t;
  typedef enum logic [1:0] {WSEL_RD = 2'd0, WSEL_RT = 2'd1, WSEL_MEM = 2'd2} wsel_t;
endpackage

// File: rtl/mips_cpu_ctrl.sv
// mips_cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM sequencer driving bus strobes and datapath write enables.
module mips_cpu_ctrl
  import mips_pkg::*;
#(
  parameter int INSTR_COUNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               instr_opcode,
  input  logic [5:0]               instr_funct,
  input  logic                     jr_target_zero,
  input  logic                     mem_waitrequest,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     mem_addr_sel,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic                     reg_we,
  output logic [1:0]               reg_wsel,
  output logic                     active,
  output logic                     illegal,
  output logic [INSTR_COUNT_W-1:0] instr_count
);
  ctrl_state_t state, state_n;
  logic is_rtype, is_addu, is_jr, is_addiu, is_lw, is_sw, legal, retire, set_illegal;
  assign is_rtype = instr_opcode == OPCODE_RTYPE;
  assign is_addu  = is_rtype && instr_funct == FUNCT_ADDU;
  assign is_jr    = is_rtype && instr_funct == FUNCT_JR;
  assign is_addiu = instr_opcode == OPCODE_ADDIU;
  assign is_lw    = instr_opcode == OPCODE_LW;
  assign is_sw    = instr_opcode == OPCODE_SW;
  assign legal    = is_addu || is_jr || is_addiu || is_lw || is_sw;
  always_comb begin
    state_n      = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    reg_wsel     = WSEL_RD;
    active       = 1'b1;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    case (state)
      ST_RESET: state_n = ST_FETCH;
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_we    = !mem_waitrequest;
        state_n  = mem_waitrequest ? ST_FETCH : ST_DECODE;
      end
      ST_DECODE: begin
        set_illegal = !legal;
        state_n     = legal ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        pc_we    = !(is_lw || is_sw);
        retire   = !(is_lw || is_sw);
        reg_we   = is_addu || is_addiu;
        reg_wsel = is_addiu ? WSEL_RT : WSEL_RD;
        state_n  = (is_lw || is_sw) ? ST_MEM : (is_jr && jr_target_zero) ? ST_HALT : ST_FETCH;
      end
      ST_MEM: begin
        mem_addr_sel = 1'b1;
        mem_read     = is_lw;
        mem_write    = !is_lw;
        pc_we        = !mem_waitrequest;
        retire       = !mem_waitrequest;
        reg_we       = is_lw && !mem_waitrequest;
        reg_wsel     = WSEL_MEM;
        state_n      = mem_waitrequest ? ST_MEM : ST_FETCH;
      end
      default: begin
        active  = 1'b0;
        state_n = ST_HALT;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RESET;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      state <= state_n;
      if (retire) instr_count <= instr_count + INSTR_COUNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_cpu_ctrl.sv
// tb_mips_cpu_ctrl: randomized instruction stream checked cycle by cycle against an instruction-level model.
module tb_mips_cpu_ctrl;
  localparam int CW = 4;
  logic clk = 0, reset = 1, jr_target_zero = 0, mem_waitrequest = 0;
  logic [5:0] instr_opcode = 0, instr_funct = 0;
  logic mem_read, mem_write, mem_addr_sel, ir_we, pc_we, reg_we, active, illegal;
  logic [1:0] reg_wsel;
  logic [CW-1:0] instr_count;
  logic [5:0] strobes;
  int vec = 0, errs = 0, count_m = 0;
  logic ill_m = 0;
  assign strobes = {mem_read, mem_write, mem_addr_sel, ir_we, pc_we, reg_we};
  always #5 clk = ~clk;
  mips_cpu_ctrl #(.INSTR_COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode), .instr_funct(instr_funct),
    .jr_target_zero(jr_target_zero), .mem_waitrequest(mem_waitrequest), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .reg_wsel(reg_wsel), .active(active), .illegal(illegal), .instr_count(instr_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  // 0 illegal, 1 addu, 2 jr, 3 addiu, 4 lw, 5 sw
  function automatic int classify(input logic [5:0] opc, input logic [5:0] fn);
    if (opc == 6'h00) return fn == 6'h21 ? 1 : fn == 6'h08 ? 2 : 0;
    return opc == 6'h09 ? 3 : opc == 6'h23 ? 4 : opc == 6'h2B ? 5 : 0;
  endfunction
  task automatic step(input logic w, input logic [5:0] exp, input logic [1:0] wsel, input logic act, input string tag);
    mem_waitrequest = w;
    @(negedge clk);
    chk({tag, "_strobes"}, strobes, exp);
    if (exp[0]) chk({tag, "_wsel"}, reg_wsel, wsel);
    chk({tag, "_active"}, active, act);
    @(posedge clk);
    #1;
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_count"}, instr_count, 64'(count_m % (1 << CW)));
    chk({tag, "_illegal"}, illegal, ill_m);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1;
    count_m = 0;
    ill_m = 0;
    #1;
    chk("async_rst_strobes", strobes, 0);
    chk("async_rst_active", active, 1);
    check_state("async_rst");
    @(posedge clk);
    #1 reset = 0;
    step(1'($urandom), 6'b000000, 0, 1, "reset_state");
  endtask
  task automatic run(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int mw,
                     input logic jz, output logic halted);
    int c;
    c = classify(opc, fn);
    halted = 0;
    instr_opcode = opc;
    instr_funct = fn;
    jr_target_zero = jz;
    for (int i = 0; i < fw; i++) step(1, 6'b100000, 0, 1, "fetch_wait");
    step(0, 6'b100100, 0, 1, "fetch");
    step(1'($urandom), 6'b000000, 0, 1, "decode");
    if (c == 0) begin
      ill_m = 1;
      halted = 1;
    end else if (c <= 3) begin
      step(1'($urandom), c == 2 ? 6'b000010 : 6'b000011, c == 3 ? 2'd1 : 2'd0, 1, "exec");
      count_m++;
      halted = c == 2 && jz;
    end else begin
      step(1'($urandom), 6'b000000, 0, 1, "exec_mem");
      for (int i = 0; i < mw; i++) step(1, c == 4 ? 6'b101000 : 6'b011000, 0, 1, "mem_wait");
      step(0, c == 4 ? 6'b101011 : 6'b011010, 2'd2, 1, "mem");
      count_m++;
    end
    check_state("retire");
    if (halted) begin
      for (int i = 0; i < 3; i++) step(1'($urandom), 6'b000000, 0, 0, "halt");
      check_state("halt");
    end
  endtask
  initial begin
    logic h;
    logic [5:0] opc, fn;
    int r;
    #1;
    chk("reset_strobes", strobes, 0);
    chk("reset_active", active, 1);
    check_state("reset");
    @(posedge clk);
    #1 reset = 0;
    step(0, 6'b000000, 0, 1, "reset_state");
    run(6'h09, 6'h15, 0, 0, 0, h);
    run(6'h23, 6'h00, 2, 3, 0, h);
    run(6'h2B, 6'h3F, 1, 2, 0, h);
    run(6'h00, 6'h21, 0, 0, 0, h);
    run(6'h00, 6'h08, 0, 0, 0, h);
    run(6'h00, 6'h08, 1, 0, 1, h);
    chk("jr_zero_halts", h, 1);
    do_reset();
    run(6'h3F, 6'h21, 0, 0, 0, h);
    chk("illegal_halts", h, 1);
    do_reset();
    // abort a stalled SW in MEM with an asynchronous reset
    run(6'h09, 6'h00, 0, 0, 0, h);
    instr_opcode = 6'h2B;
    step(0, 6'b100100, 0, 1, "abort_fetch");
    step(0, 6'b000000, 0, 1, "abort_decode");
    step(0, 6'b000000, 0, 1, "abort_exec");
    step(1, 6'b011000, 0, 1, "abort_mem_wait");
    mem_waitrequest = 1;
    #1 chk("abort_pre_write", mem_write, 1);
    reset = 1;
    count_m = 0;
    #1 chk("abort_strobes", strobes, 0);
    @(posedge clk);
    #1 reset = 0;
    check_state("abort");
    step(1, 6'b000000, 0, 1, "reset_state");
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(99);
      fn = 6'($urandom);
      opc = r < 20 ? 6'h00 : r < 40 ? 6'h09 : r < 58 ? 6'h23 : r < 76 ? 6'h2B : r < 92 ? 6'h00 : 6'($urandom);
      if (r < 20) fn = 6'h21;
      else if (r < 92 && r >= 76) fn = 6'h08;
      else if (r >= 92 && opc == 6'h00 && (fn == 6'h21 || fn == 6'h08)) fn = 6'h3F;
      run(opc, fn, $urandom_range(1) ? 0 : $urandom_range(3), $urandom_range(1) ? 0 : $urandom_range(3),
          $urandom_range(7) == 0, h);
      if (h) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mips_cpu_ctrl.md
# mips_cpu_ctrl

Multi-cycle control sequencer for the MIPS CPU core. It steps each instruction through FETCH/DECODE/EXEC/MEM and drives the bus strobes, IR/PC/register-file write enables and the write-back mux select. It handles the Avalon-style `waitrequest` handshake and stops the core on `jr` to address 0 or on an unsupported opcode. It sits beside the ALU function-code decoder and supplies the enables; the datapath owns all data registers.

## Interface
- `INSTR_COUNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces state RESET and clears the counter immediately.
- `instr_opcode` in 6: IR[31:26], valid from DECODE onward.
- `instr_funct` in 6: IR[5:0].
- `jr_target_zero` in 1: datapath flag, rs register value == 0.
- `mem_waitrequest` in 1: bus stall, high = current read/write not accepted.
- `mem_read` out 1: bus read strobe.
- `mem_write` out 1: bus write strobe.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `ir_we` out 1: load IR from bus readdata.
- `pc_we` out 1: commit next PC (PC+4, or rs for `jr`).
- `reg_we` out 1: register-file write enable.
- `reg_wsel` out 2: 0 = ALU→rd, 1 = ALU→rt, 2 = mem→rt.
- `active` out 1: high in every state except HALT.
- `illegal` out 1: sticky, set on an unsupported opcode/funct.
- `instr_count` out INSTR_COUNT_W: retired instructions.

## Operation
- State machine: RESET → FETCH → DECODE → EXEC → (MEM) → FETCH. HALT is terminal until `reset`.
- RESET: all strobes/enables 0; `active`=1; next state FETCH unconditionally.
- FETCH:
  - `mem_read`=1, `mem_addr_sel`=0.
  - While `mem_waitrequest`=1: stay; hold strobe and address.
  - On the first cycle with `mem_waitrequest`=0: `ir_we`=1, go to DECODE.
- DECODE: no strobes; register file reads. Opcode classified:
  - RTYPE (0x00) with funct ADDU (0x21) or JR (0x08).
  - ADDIU (0x09), LW (0x23), SW (0x2B).
  - Anything else: set `illegal`, go to HALT.
- EXEC:
  - ADDU: `reg_we`=1, `reg_wsel`=0.
  - ADDIU: `reg_we`=1, `reg_wsel`=1.
  - For both: `pc_we`=1, count++, go to FETCH.
  - JR: `pc_we`=1, count++; if `jr_target_zero` go to HALT, else FETCH.
  - LW/SW: go to MEM.
- MEM:
  - `mem_addr_sel`=1; `mem_read`=1 for LW, `mem_write`=1 for SW; hold while `mem_waitrequest`=1.
  - On acceptance: LW asserts `reg_we`=1, `reg_wsel`=2. Both assert `pc_we`=1, count++, go to FETCH.
- HALT: all strobes/enables 0, `active`=0; `mem_waitrequest` ignored.
- Strobe rules: never assert `mem_read` and `mem_write` together. `mem_waitrequest` is ignored outside FETCH/MEM.
- Counter: wraps modulo 2^INSTR_COUNT_W and counts the halting `jr`. It does not count illegal instructions.

## Timing
- Outputs are Moore/registered-state decode. The only combinational input paths are `ir_we`, `reg_we` and `pc_we` from `mem_waitrequest` in FETCH/MEM.
- Reset values: state RESET, `instr_count`=0, `illegal`=0, `active`=1, all other outputs 0.
- Zero-wait latency per instruction: ADDU/ADDIU/JR take 3 cycles; LW/SW take 4. Each `waitrequest` cycle adds 1.
- `reset` asserted mid-transaction aborts it. Strobes drop asynchronously and no write enable fires. After release: one RESET cycle, then FETCH.
- `illegal` stays set through HALT and clears only on `reset`.

## Structure
- Shared package `mips_pkg`:
  - OPCODE_RTYPE/ADDIU/LW/SW and FUNCT_ADDU/JR constants, shared with the ALU function-code decoder.
  - `ctrl_state_t` enum.
  - `wsel_t` encoding.
- Single module, no sub-modules. Next-state logic and output decode live in one `always_comb`; state, counter and `illegal` in one `always_ff` with asynchronous `reset`.

## Test plan
- Reset then ADDIU (0x09), zero wait → `ir_we` at cycle 1 after RESET; `reg_we`=1, `reg_wsel`=1, `pc_we`=1 at cycle 3; `instr_count`=1.
- LW (0x23) with `mem_waitrequest` high for 2 cycles in FETCH and 3 in MEM → `mem_read` held steady; `reg_wsel`=2 and `reg_we` pulse once; 9 cycles from FETCH to return to FETCH.
- SW (0x2B) → `mem_write`=1 with `mem_addr_sel`=1 in MEM; `mem_read`=0 throughout MEM; `reg_we` never asserted.
- RTYPE funct 0x08 with `jr_target_zero`=1 → `pc_we` pulse, then HALT: `active`=0, `instr_count` incremented. `mem_waitrequest` toggling afterward produces no strobes.
- Opcode 0x3F → `illegal`=1, HALT, `instr_count` unchanged; `reset` clears `illegal` and restarts at FETCH.
- `reset` asserted during a stalled MEM of SW → `mem_write` drops in the same cycle, no `pc_we`; the counter reads 0 after release.
